// File: rtl/clkdiv_sched.sv
// clkdiv_sched: gated 16-bit divider counter with per-channel power-of-two tick enables and wrap-synchronous config
module clkdiv_sched #(
    parameter int NCH = 4,
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic             cmd_pause,
    input  logic             cmd_stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_ch,
    input  logic             cfg_en,
    input  logic [3:0]       cfg_shift,
    output logic [W-1:0]     cnt,
    output logic [NCH-1:0]   tick,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
    state_t                state_q, state_d;
    logic [W-1:0]          cnt_q, cnt_d;
    logic [NCH-1:0]        tick_q, tick_d;
    logic [NCH-1:0]        en_q, en_d;
    logic [NCH-1:0][3:0]   shift_q, shift_d;
    logic [NCH-1:0][W-1:0] mask;
    logic                  cfg_ready_q, cfg_ready_d;
    logic [1:0]            sh_ch_q, sh_ch_d;
    logic                  sh_en_q, sh_en_d;
    logic [3:0]            sh_shift_q, sh_shift_d;
    logic                  run, leave, run_go, accept, apply_sh;
    always_comb begin
        run      = state_q == RUN;
        leave    = run && (cmd_stop || cmd_pause);
        run_go   = run && !leave;
        accept   = cfg_valid && cfg_ready_q;
        // cfg_ready low doubles as "shadow full"
        apply_sh = !cfg_ready_q && (leave || (run_go && cnt_q == '1));
        state_d  = cmd_stop ? IDLE : leave ? PAUSE : (cmd_start && !run) ? RUN : state_q;
        cnt_d    = cmd_stop ? '0 : run_go ? cnt_q + W'(1) : cnt_q;
        en_d     = en_q;
        shift_d  = shift_q;
        for (int i = 0; i < NCH; i++) begin
            mask[i]   = {W{1'b1}} >> (W - 1 - int'(shift_q[i]));
            tick_d[i] = run_go && en_q[i] && ((cnt_q & mask[i]) == mask[i]);
        end
        if (apply_sh) begin
            en_d[sh_ch_q]    = sh_en_q;
            shift_d[sh_ch_q] = sh_shift_q;
        end
        if (accept && !run_go) begin
            en_d[cfg_ch]    = cfg_en;
            shift_d[cfg_ch] = cfg_shift;
        end
        sh_ch_d     = (accept && run_go) ? cfg_ch : sh_ch_q;
        sh_en_d     = (accept && run_go) ? cfg_en : sh_en_q;
        sh_shift_d  = (accept && run_go) ? cfg_shift : sh_shift_q;
        cfg_ready_d = (accept && run_go) ? 1'b0 : apply_sh ? 1'b1 : cfg_ready_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tick_q      <= '0;
            en_q        <= '0;
            shift_q     <= '0;
            cfg_ready_q <= 1'b1;
            sh_ch_q     <= '0;
            sh_en_q     <= 1'b0;
            sh_shift_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            en_q        <= en_d;
            shift_q     <= shift_d;
            cfg_ready_q <= cfg_ready_d;
            sh_ch_q     <= sh_ch_d;
            sh_en_q     <= sh_en_d;
            sh_shift_q  <= sh_shift_d;
        end
    end
    assign cnt       = cnt_q;
    assign tick      = tick_q;
    assign state     = state_q;
    assign cfg_ready = cfg_ready_q;
endmodule

// File: tb/tb_clkdiv_sched.sv
// tb_clkdiv_sched: directed stimulus, cycle-level behavioural model and literal anchor checks for clkdiv_sched
module tb_clkdiv_sched;
    logic        clk = 0, rst = 0;
    logic        cmd_start = 0, cmd_pause = 0, cmd_stop = 0;
    logic        cfg_valid = 0, cfg_en = 0, cfg_ready;
    logic [1:0]  cfg_ch = 0;
    logic [3:0]  cfg_shift = 0;
    logic [15:0] cnt;
    logic [3:0]  tick;
    logic [1:0]  state;
    int n_cmp = 0, n_fail = 0;
    bit chk_on = 0;

    clkdiv_sched #(.NCH(4), .W(16)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_pause(cmd_pause), .cmd_stop(cmd_stop),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
        .cfg_shift(cfg_shift), .cnt(cnt), .tick(tick), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {int ch; bit en; int sh;} cfg_t;
    cfg_t shq[$];
    int   m_state, m_cnt;
    bit   m_ready;
    bit   m_en[4];
    int   m_sh[4];
    logic [3:0] m_tick;

    // Model: tick whenever the freshly incremented count is a multiple of 2^(s+1)
    always @(posedge clk) begin
        bit run, leaving, incr, acc;
        int nxt;
        cfg_t w;
        if (!rst) begin
            m_state = 0; m_cnt = 0; m_tick = 0; m_ready = 1; shq.delete();
            for (int i = 0; i < 4; i++) begin m_en[i] = 0; m_sh[i] = 0; end
        end else begin
            run = (m_state == 1);
            leaving = run && (cmd_stop || cmd_pause);
            incr = run && !leaving;
            acc = cfg_valid && m_ready;
            nxt = (m_cnt + 1) % 65536;
            for (int i = 0; i < 4; i++)
                m_tick[i] = incr && m_en[i] && (nxt % (1 << (m_sh[i] + 1)) == 0);
            if ((leaving || (incr && nxt == 0)) && shq.size() > 0) begin
                w = shq.pop_front();
                m_en[w.ch] = w.en; m_sh[w.ch] = w.sh;
            end
            if (acc) begin
                w.ch = int'(cfg_ch); w.en = cfg_en; w.sh = int'(cfg_shift);
                if (incr) shq.push_back(w);
                else begin m_en[w.ch] = w.en; m_sh[w.ch] = w.sh; end
            end
            m_ready = (shq.size() == 0);
            m_cnt = cmd_stop ? 0 : incr ? nxt : m_cnt;
            m_state = cmd_stop ? 0 : (run && cmd_pause) ? 2 : (cmd_start && !run) ? 1 : m_state;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) if (chk_on) begin
        check("cnt", 32'(cnt), m_cnt);
        check("tick", 32'(tick), 32'(m_tick));
        check("state", 32'(state), m_state);
        check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    end

    task automatic pulse(input bit s, input bit p, input bit t);
        cmd_start = s; cmd_pause = p; cmd_stop = t;
        @(negedge clk);
        cmd_start = 0; cmd_pause = 0; cmd_stop = 0;
    endtask

    task automatic wr(input logic [1:0] ch, input logic en, input logic [3:0] sh);
        cfg_valid = 1; cfg_ch = ch; cfg_en = en; cfg_shift = sh;
        @(negedge clk);
        cfg_valid = 0;
    endtask

    task automatic wait_cnt(input logic [15:0] v);
        int n = 0;
        while (cnt !== v && n < 70000) begin @(negedge clk); n++; end
        check("wait_cnt", 32'(cnt), 32'(v));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_on = 1;
        check("rst_cnt", 32'(cnt), 0);
        check("rst_state", 32'(state), 0);
        check("rst_ready", 32'(cfg_ready), 1);
        check("rst_tick", 32'(tick), 0);
        rst = 1;
        @(negedge clk);
        pulse(0, 1, 0);
        check("pause_in_idle", 32'(state), 0);
        wr(0, 1, 0);
        check("idle_wr_ready", 32'(cfg_ready), 1);
        pulse(1, 0, 0);
        check("start_state", 32'(state), 1);
        check("start_cnt", 32'(cnt), 0);
        @(negedge clk);
        check("cnt1", 32'(cnt), 1);
        check("tick_at_1", 32'(tick), 0);
        @(negedge clk);
        check("cnt2", 32'(cnt), 2);
        check("tick_s0", 32'(tick), 32'h1);
        wr(1, 1, 3);
        check("shadow_ready", 32'(cfg_ready), 0);
        pulse(1, 0, 0);
        check("start_in_run", 32'(state), 1);
        wait_cnt(16'hffff);
        check("pre_wrap_ready", 32'(cfg_ready), 0);
        @(negedge clk);
        check("wrap_cnt", 32'(cnt), 0);
        check("wrap_ready", 32'(cfg_ready), 1);
        check("wrap_tick_old_cfg", 32'(tick), 32'h1);
        repeat (16) @(negedge clk);
        check("tick_s3", 32'(tick), 32'h3);
        wait_cnt(16'h1234);
        pulse(0, 1, 0);
        check("pause_cnt", 32'(cnt), 32'h1234);
        check("pause_state", 32'(state), 2);
        check("pause_tick", 32'(tick), 0);
        repeat (3) @(negedge clk);
        check("paused_hold", 32'(cnt), 32'h1234);
        pulse(1, 0, 0);
        check("resume_state", 32'(state), 1);
        @(negedge clk);
        check("resume_cnt", 32'(cnt), 32'h1235);
        wr(2, 1, 2);
        check("shadow2_ready", 32'(cfg_ready), 0);
        repeat (2) @(negedge clk);
        pulse(0, 1, 0);
        check("leave_apply_ready", 32'(cfg_ready), 1);
        check("leave_state", 32'(state), 2);
        pulse(1, 0, 0);
        wait_cnt(16'h1240);
        check("tick_s2", 32'(tick), 32'h7);
        @(negedge clk);
        cmd_start = 1; cmd_pause = 1; cmd_stop = 1;
        @(negedge clk);
        cmd_start = 0; cmd_pause = 0; cmd_stop = 0;
        check("stop_state", 32'(state), 0);
        check("stop_cnt", 32'(cnt), 0);
        check("stop_tick", 32'(tick), 0);
        pulse(1, 0, 0);
        wr(3, 1, 1);
        check("shadow3_ready", 32'(cfg_ready), 0);
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        check("mid_rst_cnt", 32'(cnt), 0);
        check("mid_rst_state", 32'(state), 0);
        check("mid_rst_tick", 32'(tick), 0);
        check("mid_rst_ready", 32'(cfg_ready), 1);
        pulse(1, 0, 0);
        repeat (40) @(negedge clk);
        check("post_rst_tick", 32'(tick), 0);
        check("post_rst_cnt", 32'(cnt), 40);
        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/clkdiv_sched.md
# clkdiv_sched

Tick scheduler and sequencer for the free-running 16-bit clock divider. It owns the divider counter and gates it with start, pause and stop commands. It shares the counter among four consumers (display scan, key debounce, blinker, spare), each of which receives single-cycle clock-enable ticks at a programmable power-of-two period instead of a derived clock. Per-channel configuration is written through a valid/ready port and applied glitch-free at counter wrap while running.

## Interface
- `NCH`, 4: number of tick channels.
- `W`, 16: divider counter width; shift field is 4 bits (0..W-1).
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-low reset; sampled only on rising `clk`.
- `cmd_start` in 1: pulse; IDLE/PAUSE -> RUN.
- `cmd_pause` in 1: pulse; RUN -> PAUSE.
- `cmd_stop` in 1: pulse; any state -> IDLE, counter cleared.
- `cfg_valid` in 1: config write request.
- `cfg_ready` out 1: config write accepted when `cfg_valid && cfg_ready` at a rising edge.
- `cfg_ch` in 2: target channel.
- `cfg_en` in 1: channel enable.
- `cfg_shift` in 4: channel period exponent s; period = 2^(s+1) cycles.
- `cnt` out W: divider counter value (registered).
- `tick` out NCH: per-channel one-cycle enable pulses (registered).
- `state` out 2: 00 IDLE, 01 RUN, 10 PAUSE.

## Operation
- Reset (`rst`=0 at edge):
  - `cnt`=0, `tick`=0, `state`=IDLE, `cfg_ready`=1.
  - All channels: en=0, shift=0.
  - Shadow register empty.
- Command priority in the same cycle: stop > pause > start.
  - Commands that are illegal for the current state are ignored: pause outside RUN, start in RUN.
- IDLE: `cnt` held at 0, `tick`=0.
- RUN: `cnt` <= `cnt`+1 every cycle, wrapping FFFF->0000.
- PAUSE: `cnt` frozen, `tick`=0. A start command resumes from the frozen value.
- Stop: `cnt` <= 0 and `tick` <= 0 at the same edge.
- Tick rule: on an edge in RUN where the pre-increment `cnt` has bits [s:0] all ones and en=1, `tick[i]` <= 1; otherwise `tick[i]` <= 0.
  - Net effect: `tick[i]` is high in the cycle where `cnt[s:0]` == 0, after each increment.
  - s=15: one tick per 65536 cycles, at the wrap.
- Config writes in IDLE or PAUSE: applied directly to the channel at the accepting edge. `cfg_ready` stays 1.
- Config writes in RUN:
  - The accepted write is latched into a one-entry shadow register, and `cfg_ready` <= 0.
  - The shadow is applied on the edge where `cnt` wraps FFFF->0000. The tick generated at that edge uses the old configuration.
  - `cfg_ready` returns to 1 at the same edge.
- Leaving RUN (pause or stop) with the shadow full: the shadow is applied at that transition edge and `cfg_ready` <= 1.
- Accepted write in the same cycle as pause or stop from RUN: applied directly at that edge, not shadowed.
- Start in the same cycle as an accepted write in IDLE/PAUSE: the write is applied directly, and RUN begins with the new configuration.
- Reset during RUN with a pending shadow: the shadow is discarded and all state returns to reset values.

## Timing
- Command-to-state latency: 1 cycle. The first increment occurs on the edge after `state` reads RUN.
  - Start at edge E: `state`=RUN after E, `cnt`=1 after E+1.
- Tick latency: registered, zero added skew relative to `cnt`; `tick` and its matching `cnt` value appear together.
- Tick width: exactly 1 cycle for every s, including s=0 (period 2, 50% duty).
- Config in RUN, worst case: a write accepted just after a wrap waits 65535 cycles to apply.
- `cfg_ready` low time: from the acceptance edge to the applying edge.
- No combinational path from any input to any output.

## Test plan
- Reset then start, ch0 en=1 s=0 written in IDLE -> `tick[0]` high every 2nd cycle, coinciding with `cnt` = 2, 4, 6…; other ticks 0.
- ch1 s=3 in RUN -> first write applied only after `cnt` wraps to 0000, with `cfg_ready` low until that edge. Afterwards `tick[1]` is high when `cnt[3:0]`==0, i.e. every 16 cycles.
- RUN at `cnt`=0x1234, then pause -> `cnt` holds 0x1234 and ticks are 0. Start -> `cnt`=0x1235 on the next edge.
- Stop, pause and start asserted in the same cycle during RUN -> `state`=IDLE, `cnt`=0.
- Shadow pending (ch2 en=1 s=2), then pause -> ch2 config applied at the pause edge and `cfg_ready`=1. After resume, `tick[2]` fires every 8 cycles.
- `rst`=0 mid-RUN with a pending shadow -> next cycle `cnt`=0, `state`=IDLE, `tick`=0, `cfg_ready`=1. Start then produces no ticks (all channels disabled).
